// File: rtl/decode_pkg.sv
// Shared types for the RV32I/RV32E decode stage: opcodes, function fields, kinds, queue entry, error causes.
// The M-extension kinds are always declared; DECODE_MEXT_EN in decode_comb decides whether they are produced.
package decode_pkg;

    localparam int REG_FIELD_W = 5;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
        F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7
    } alu_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4,
        F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7
    } branch_f3_e;

    typedef enum logic [6:0] {
        F7_BASE   = 7'b0000000,
        F7_MULDIV = 7'b0000001,
        F7_ALT    = 7'b0100000
    } funct7_e;

    typedef enum logic [5:0] {
        INST_NOP = 6'd0,
        INST_LUI, INST_AUIPC, INST_JAL, INST_JALR,
        INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU,
        INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
        INST_SB, INST_SH, INST_SW,
        INST_ADDI, INST_SLTI, INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI,
        INST_SLLI, INST_SRLI, INST_SRAI,
        INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU,
        INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND,
        INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
        INST_DIV, INST_DIVU, INST_REM, INST_REMU
    } instruction_kind;

    typedef struct packed {
        instruction_kind         kind;
        logic [31:0]             address;
        logic [31:0]             immediate;
        logic [REG_FIELD_W-1:0]  rd;
        logic [REG_FIELD_W-1:0]  rs1;
        logic [REG_FIELD_W-1:0]  rs2;
        logic                    uses_rd;
        logic                    uses_rs1;
        logic                    uses_rs2;
    } decoded_entry;

    typedef enum logic [1:0] {
        ERR_NONE           = 2'd0,
        ERR_ILLEGAL_OPCODE = 2'd1,
        ERR_ILLEGAL_FUNCT  = 2'd2,
        ERR_REG_RANGE      = 2'd3
    } err_cause_e;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV32E decode: raw encoding + PC in, queue entry + error cause out.
// DECODE_MEXT_EN enables the M-extension kinds for OP with funct7 = 0000001.
module decode_comb
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [31:0]  instruction_i,
    input  logic [31:0]  address_i,
    output decoded_entry entry_o,
    output err_cause_e   cause_o
);

    localparam logic [5:0] NR = 6'(NUM_REGS);

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [31:0] imm;
    logic        use_rd, use_rs1, use_rs2, bad_op, bad_fn, bad_reg;

    assign ins    = instruction_i;
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_sh = {27'b0, ins[24:20]};

    always_comb begin
        entry_o         = '0;
        entry_o.kind    = INST_NOP;
        entry_o.address = address_i;
        imm     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad_op  = 1'b0;
        bad_fn  = 1'b0;
        case (ins[6:0])
            OPC_LUI:   begin entry_o.kind = INST_LUI;   use_rd = 1'b1; imm = imm_u; end
            OPC_AUIPC: begin entry_o.kind = INST_AUIPC; use_rd = 1'b1; imm = imm_u; end
            OPC_JAL:   begin entry_o.kind = INST_JAL;   use_rd = 1'b1; imm = imm_j; end
            OPC_JALR: begin
                entry_o.kind = INST_JALR;
                use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
            end
            OPC_OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
                case (f3)
                    F3_ADD:  entry_o.kind = INST_ADDI;
                    F3_SLT:  entry_o.kind = INST_SLTI;
                    F3_SLTU: entry_o.kind = INST_SLTIU;
                    F3_XOR:  entry_o.kind = INST_XORI;
                    F3_OR:   entry_o.kind = INST_ORI;
                    F3_AND:  entry_o.kind = INST_ANDI;
                    F3_SLL: begin
                        entry_o.kind = INST_SLLI;
                        imm = imm_sh;
                        bad_fn = (f7 != F7_BASE);
                    end
                    default: begin
                        imm = imm_sh;
                        if (f7 == F7_BASE)     entry_o.kind = INST_SRLI;
                        else if (f7 == F7_ALT) entry_o.kind = INST_SRAI;
                        else                   bad_fn = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f7)
                    F7_BASE: begin
                        case (f3)
                            F3_ADD:  entry_o.kind = INST_ADD;
                            F3_SLL:  entry_o.kind = INST_SLL;
                            F3_SLT:  entry_o.kind = INST_SLT;
                            F3_SLTU: entry_o.kind = INST_SLTU;
                            F3_XOR:  entry_o.kind = INST_XOR;
                            F3_SR:   entry_o.kind = INST_SRL;
                            F3_OR:   entry_o.kind = INST_OR;
                            default: entry_o.kind = INST_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (f3 == F3_ADD)     entry_o.kind = INST_SUB;
                        else if (f3 == F3_SR) entry_o.kind = INST_SRA;
                        else                  bad_fn = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    F7_MULDIV: begin
                        case (f3)
                            3'd0:    entry_o.kind = INST_MUL;
                            3'd1:    entry_o.kind = INST_MULH;
                            3'd2:    entry_o.kind = INST_MULHSU;
                            3'd3:    entry_o.kind = INST_MULHU;
                            3'd4:    entry_o.kind = INST_DIV;
                            3'd5:    entry_o.kind = INST_DIVU;
                            3'd6:    entry_o.kind = INST_REM;
                            default: entry_o.kind = INST_REMU;
                        endcase
                    end
`endif
                    default: bad_fn = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
                case (f3)
                    F3_BEQ:  entry_o.kind = INST_BEQ;
                    F3_BNE:  entry_o.kind = INST_BNE;
                    F3_BLT:  entry_o.kind = INST_BLT;
                    F3_BGE:  entry_o.kind = INST_BGE;
                    F3_BLTU: entry_o.kind = INST_BLTU;
                    F3_BGEU: entry_o.kind = INST_BGEU;
                    default: bad_fn = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
                case (f3)
                    3'd0:    entry_o.kind = INST_LB;
                    3'd1:    entry_o.kind = INST_LH;
                    3'd2:    entry_o.kind = INST_LW;
                    3'd4:    entry_o.kind = INST_LBU;
                    3'd5:    entry_o.kind = INST_LHU;
                    default: bad_fn = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
                case (f3)
                    3'd0:    entry_o.kind = INST_SB;
                    3'd1:    entry_o.kind = INST_SH;
                    3'd2:    entry_o.kind = INST_SW;
                    default: bad_fn = 1'b1;
                endcase
            end
            OPC_MISC_MEM, OPC_SYSTEM: entry_o.kind = INST_NOP;
            default: bad_op = 1'b1;
        endcase

        // Unused fields read as zero so they never alias a real register.
        entry_o.immediate = imm;
        entry_o.uses_rd   = use_rd;
        entry_o.uses_rs1  = use_rs1;
        entry_o.uses_rs2  = use_rs2;
        entry_o.rd        = use_rd  ? ins[11:7]  : '0;
        entry_o.rs1       = use_rs1 ? ins[19:15] : '0;
        entry_o.rs2       = use_rs2 ? ins[24:20] : '0;

        bad_reg = ({1'b0, entry_o.rd}  >= NR && use_rd)
               || ({1'b0, entry_o.rs1} >= NR && use_rs1)
               || ({1'b0, entry_o.rs2} >= NR && use_rs2);

        if (bad_op)       cause_o = ERR_ILLEGAL_OPCODE;
        else if (bad_fn)  cause_o = ERR_ILLEGAL_FUNCT;
        else if (bad_reg) cause_o = ERR_REG_RANGE;
        else              cause_o = ERR_NONE;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage top: fetch handshake, DEPTH-entry output queue, flush and latched error report.
// Optional M-extension decode is selected by DECODE_MEXT_EN (see decode_comb).
module decode_stage
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DEPTH    = 2,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [31:0]     in_address,
    output logic            out_valid,
    input  logic            out_ready,
    output instruction_kind out_kind,
    output logic [31:0]     out_address,
    output logic [31:0]     out_immediate,
    output logic [RW-1:0]   out_rd,
    output logic [RW-1:0]   out_rs1,
    output logic [RW-1:0]   out_rs2,
    output logic            out_uses_rd,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic [RW-1:0]   rf_read_loc_1,
    output logic [RW-1:0]   rf_read_loc_2,
    input  logic            flush,
    output logic            err_valid,
    output logic [1:0]      err_cause,
    output logic [31:0]     err_instruction,
    output logic [31:0]     err_address,
    input  logic            err_clear
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    decoded_entry dec_entry;
    err_cause_e   dec_cause;

    decode_comb #(.NUM_REGS(NUM_REGS)) u_decode (
        .instruction_i (in_instruction),
        .address_i     (in_address),
        .entry_o       (dec_entry),
        .cause_o       (dec_cause)
    );

    decoded_entry    mem_q [DEPTH];
    decoded_entry    head;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_valid_q, err_valid_d;
    err_cause_e      err_cause_q, err_cause_d;
    logic [31:0]     err_instr_q, err_instr_d, err_addr_q, err_addr_d;
    logic            accept, push, pop, capture;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = !err_valid_q && (count_q < CW'(DEPTH));
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && (dec_cause == ERR_NONE);
    assign capture  = accept && (dec_cause != ERR_NONE);
    assign pop      = out_valid && out_ready && !flush;

    always_comb begin
        wr_d        = wr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        err_valid_d = err_valid_q;
        err_cause_d = err_cause_q;
        err_instr_d = err_instr_q;
        err_addr_d  = err_addr_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wrap_inc(wr_q);
            if (pop)  rd_d = wrap_inc(rd_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        // A fresh error outranks a clear in the same cycle.
        if (capture) begin
            err_valid_d = 1'b1;
            err_cause_d = dec_cause;
            err_instr_d = in_instruction;
            err_addr_d  = in_address;
        end else if (err_clear) begin
            err_valid_d = 1'b0;
            err_cause_d = ERR_NONE;
            err_instr_d = '0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= ERR_NONE;
            err_instr_q <= '0;
            err_addr_q  <= '0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            err_instr_q <= err_instr_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= dec_entry;
    end

    // Outputs are forced to zero while empty so reset and drained states look identical.
    assign head          = mem_q[rd_q];
    assign out_valid     = (count_q != '0);
    assign out_kind      = out_valid ? head.kind : INST_NOP;
    assign out_address   = out_valid ? head.address : '0;
    assign out_immediate = out_valid ? head.immediate : '0;
    assign out_rd        = out_valid ? head.rd[RW-1:0] : '0;
    assign out_rs1       = out_valid ? head.rs1[RW-1:0] : '0;
    assign out_rs2       = out_valid ? head.rs2[RW-1:0] : '0;
    assign out_uses_rd   = out_valid && head.uses_rd;
    assign out_uses_rs1  = out_valid && head.uses_rs1;
    assign out_uses_rs2  = out_valid && head.uses_rs2;
    assign rf_read_loc_1 = (out_valid && head.uses_rs1) ? head.rs1[RW-1:0] : '0;
    assign rf_read_loc_2 = (out_valid && head.uses_rs2) ? head.rs2[RW-1:0] : '0;

    generate
        if (RW < REG_FIELD_W) begin : g_narrow_rf
            // Queued entries already passed the range check, so the high field bits are always zero.
            logic unused_hi;
            assign unused_hi = ^{head.rd[REG_FIELD_W-1:RW], head.rs1[REG_FIELD_W-1:RW],
                                 head.rs2[REG_FIELD_W-1:RW]};
        end
    endgenerate

    assign err_valid       = err_valid_q;
    assign err_cause       = err_cause_q;
    assign err_instruction = err_instr_q;
    assign err_address     = err_addr_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a queue-based reference model.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int NUM_REGS = 16;
    localparam int DEPTH    = 2;
    localparam int RW       = $clog2(NUM_REGS);

    logic clock = 1'b0;
    logic nreset;
    logic in_valid, in_ready, out_valid, out_ready, flush, err_clear, err_valid;
    logic [31:0] in_instruction, in_address, out_address, out_immediate;
    logic [31:0] err_instruction, err_address;
    instruction_kind out_kind;
    logic [RW-1:0] out_rd, out_rs1, out_rs2, rf_read_loc_1, rf_read_loc_2;
    logic out_uses_rd, out_uses_rs1, out_uses_rs2;
    logic [1:0] err_cause;

    decode_stage #(.NUM_REGS(NUM_REGS), .DEPTH(DEPTH)) dut (
        .clock(clock), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_address(in_address),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_address(out_address), .out_immediate(out_immediate),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_uses_rd(out_uses_rd), .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .rf_read_loc_1(rf_read_loc_1), .rf_read_loc_2(rf_read_loc_2),
        .flush(flush), .err_valid(err_valid), .err_cause(err_cause),
        .err_instruction(err_instruction), .err_address(err_address),
        .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        instruction_kind kind;
        logic [31:0] addr;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        u_rd, u_rs1, u_rs2;
        logic [1:0]  cause;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: table lookups by funct3 plus per-format immediate arithmetic.
    function automatic exp_t mdec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        instruction_kind alu_k [8], imm_k [8], br_k [8], ld_k [8], st_k [8], mul_k [8];
        logic [7:0] br_ok, ld_ok, st_ok;
        logic [6:0] op, f7;
        int f3;
        byte fmt;
        logic ok_op, ok_fn;
        logic signed [31:0] sx;
        alu_k = '{INST_ADD, INST_SLL, INST_SLT, INST_SLTU, INST_XOR, INST_SRL, INST_OR, INST_AND};
        imm_k = '{INST_ADDI, INST_SLLI, INST_SLTI, INST_SLTIU, INST_XORI, INST_SRLI, INST_ORI, INST_ANDI};
        br_k  = '{INST_BEQ, INST_BNE, INST_NOP, INST_NOP, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU};
        ld_k  = '{INST_LB, INST_LH, INST_LW, INST_NOP, INST_LBU, INST_LHU, INST_NOP, INST_NOP};
        st_k  = '{INST_SB, INST_SH, INST_SW, INST_NOP, INST_NOP, INST_NOP, INST_NOP, INST_NOP};
        mul_k = '{INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU, INST_DIV, INST_DIVU, INST_REM, INST_REMU};
        br_ok = 8'b1111_0011;
        ld_ok = 8'b0011_0111;
        st_ok = 8'b0000_0111;
        op = ins[6:0]; f7 = ins[31:25]; f3 = int'(ins[14:12]); sx = ins;
        ok_op = 1'b1; ok_fn = 1'b1; fmt = "N";
        e = '{kind: INST_NOP, addr: pc, imm: 0, rd: 0, rs1: 0, rs2: 0,
              u_rd: 0, u_rs1: 0, u_rs2: 0, cause: 0};
        case (op)
            7'h37: begin fmt = "U"; e.kind = INST_LUI; end
            7'h17: begin fmt = "U"; e.kind = INST_AUIPC; end
            7'h6F: begin fmt = "J"; e.kind = INST_JAL; end
            7'h67: begin fmt = "I"; e.kind = INST_JALR; end
            7'h13: begin
                fmt = "I"; e.kind = imm_k[f3];
                if (f3 == 1) begin fmt = "H"; ok_fn = (f7 == 7'h00); end
                if (f3 == 5) begin
                    fmt = "H"; ok_fn = (f7 == 7'h00) || (f7 == 7'h20);
                    e.kind = (f7 == 7'h20) ? INST_SRAI : INST_SRLI;
                end
            end
            7'h33: begin
                fmt = "R";
                if (f7 == 7'h00) e.kind = alu_k[f3];
                else if (f7 == 7'h20 && f3 == 0) e.kind = INST_SUB;
                else if (f7 == 7'h20 && f3 == 5) e.kind = INST_SRA;
`ifdef DECODE_MEXT_EN
                else if (f7 == 7'h01) e.kind = mul_k[f3];
`endif
                else ok_fn = 1'b0;
            end
            7'h63: begin fmt = "B"; e.kind = br_k[f3]; ok_fn = br_ok[f3]; end
            7'h03: begin fmt = "I"; e.kind = ld_k[f3]; ok_fn = ld_ok[f3]; end
            7'h23: begin fmt = "S"; e.kind = st_k[f3]; ok_fn = st_ok[f3]; end
            7'h0F, 7'h73: fmt = "N";
            default: ok_op = 1'b0;
        endcase
        case (fmt)
            "U": begin e.u_rd = 1; e.imm = ins & 32'hFFFF_F000; end
            "J": begin e.u_rd = 1; e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            "I": begin e.u_rd = 1; e.u_rs1 = 1; e.imm = 32'(sx >>> 20); end
            "H": begin e.u_rd = 1; e.u_rs1 = 1; e.imm = 32'(ins[24:20]); end
            "R": begin e.u_rd = 1; e.u_rs1 = 1; e.u_rs2 = 1; end
            "B": begin e.u_rs1 = 1; e.u_rs2 = 1;
                       e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            "S": begin e.u_rs1 = 1; e.u_rs2 = 1; e.imm = 32'((sx >>> 25) << 5) | 32'(ins[11:7]); end
            default: ;
        endcase
        if (!ok_op) begin e.u_rd = 0; e.u_rs1 = 0; e.u_rs2 = 0; e.imm = 0; end
        e.rd  = e.u_rd  ? ins[11:7]  : 5'd0;
        e.rs1 = e.u_rs1 ? ins[19:15] : 5'd0;
        e.rs2 = e.u_rs2 ? ins[24:20] : 5'd0;
        if (!ok_op)      e.cause = 2'd1;
        else if (!ok_fn) e.cause = 2'd2;
        else if ((e.u_rd && e.rd >= NUM_REGS) || (e.u_rs1 && e.rs1 >= NUM_REGS)
                 || (e.u_rs2 && e.rs2 >= NUM_REGS)) e.cause = 2'd3;
        return e;
    endfunction

    // Reference state: a queue of expected entries and the error latch.
    exp_t q[$];
    logic m_err_v = 1'b0;
    logic [1:0] m_err_c = '0;
    logic [31:0] m_err_i = '0, m_err_a = '0;

    initial begin : model
        exp_t d;
        logic rdy, acc, popped;
        forever begin
            @(posedge clock or negedge nreset);
            if (!nreset) begin
                q.delete();
                m_err_v = 0; m_err_c = 0; m_err_i = 0; m_err_a = 0;
            end else begin
                rdy    = !m_err_v && q.size() < DEPTH;
                acc    = in_valid && rdy && !flush;
                popped = q.size() != 0 && out_ready && !flush;
                d      = mdec(in_instruction, in_address);
                if (flush) q.delete();
                else begin
                    if (popped) void'(q.pop_front());
                    if (acc && d.cause == 0) q.push_back(d);
                end
                if (acc && d.cause != 0) begin
                    m_err_v = 1; m_err_c = d.cause; m_err_i = in_instruction; m_err_a = in_address;
                end else if (err_clear) begin
                    m_err_v = 0; m_err_c = 0; m_err_i = 0; m_err_a = 0;
                end
            end
        end
    end

    initial begin : compare
        exp_t h;
        forever begin
            @(negedge clock);
            check("in_ready", 32'(in_ready), 32'(!m_err_v && q.size() < DEPTH));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("err_valid", 32'(err_valid), 32'(m_err_v));
            check("err_cause", 32'(err_cause), 32'(m_err_c));
            check("err_instruction", err_instruction, m_err_i);
            check("err_address", err_address, m_err_a);
            if (q.size() != 0) begin
                h = q[0];
                check("out_kind", 32'(out_kind), 32'(h.kind));
                check("out_address", out_address, h.addr);
                check("out_immediate", out_immediate, h.imm);
                check("out_rd", 32'(out_rd), 32'(h.rd));
                check("out_rs1", 32'(out_rs1), 32'(h.rs1));
                check("out_rs2", 32'(out_rs2), 32'(h.rs2));
                check("out_uses", 32'({out_uses_rd, out_uses_rs1, out_uses_rs2}),
                      32'({h.u_rd, h.u_rs1, h.u_rs2}));
                check("rf_read_loc_1", 32'(rf_read_loc_1), 32'(h.rs1));
                check("rf_read_loc_2", 32'(rf_read_loc_2), 32'(h.rs2));
            end else begin
                check("rf_read_loc_idle", 32'({rf_read_loc_1, rf_read_loc_2}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1; in_instruction = ins; in_address = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] r;
        logic [6:0] op, f7;
        int pick;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};
        r = $urandom();
        if ($urandom_range(0, 19) == 0) return r;
        pick = $urandom_range(0, 11);
        op = (pick < 11) ? ops[pick] : r[6:0];
        pick = $urandom_range(0, 9);
        f7 = (pick < 5) ? 7'h00 : (pick < 7) ? 7'h20 : (pick < 9) ? 7'h01 : r[31:25];
        return {f7, rand_reg(), rand_reg(), 3'($urandom_range(0, 7)), rand_reg(), op};
    endfunction

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin : stim
        exp_t m;
        nreset = 1'b0; in_valid = 0; in_instruction = 0; in_address = 0;
        out_ready = 1'b1; flush = 0; err_clear = 0;

        // Pin the reference decode on hand-computed encodings.
        m = mdec(32'h00500093, 0);
        check("pin_addi", {26'(m.kind), m.rd, 1'(m.cause)}, {26'(INST_ADDI), 5'd1, 1'b0});
        check("pin_addi_imm", m.imm, 32'd5);
        m = mdec(32'hFE208EE3, 0);
        check("pin_beq_imm", m.imm, 32'hFFFF_FFFC);
        m = mdec(32'hFE20AC23, 0);
        check("pin_sw_imm", m.imm, 32'hFFFF_FFF8);
        m = mdec(32'h008000EF, 0);
        check("pin_jal_imm", m.imm, 32'd8);
        m = mdec(32'h123452B7, 0);
        check("pin_lui_imm", m.imm, 32'h1234_5000);
        m = mdec(32'h4030D093, 0);
        check("pin_srai", {26'(m.kind), 6'(m.imm)}, {26'(INST_SRAI), 6'd3});
        m = mdec(32'h00002063, 0);
        check("pin_bad_branch", 32'(m.cause), 32'd2);
        m = mdec(32'h00100813, 0);
        check("pin_reg_range", 32'(m.cause), 32'd3);

        tick(); tick();
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_kind", 32'(out_kind), 32'(INST_NOP));
        check("rst_out_bus", out_address | out_immediate, 32'd0);
        check("rst_err", {err_valid, 1'b0, err_cause, err_instruction[27:0]}, 32'd0);
        tick();
        nreset = 1'b1;
        tick();

        send(32'h00500093, 32'h100);
        @(negedge clock);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_kind", 32'(out_kind), 32'(INST_ADDI));
        check("addi_fields", {out_rd, out_rs1, 23'd0, out_uses_rs2}, {4'd1, 4'd0, 24'd0});
        check("addi_imm", out_immediate, 32'd5);

        send(32'h000100E7, 32'h104);
        @(negedge clock);
        check("jalr_kind", 32'(out_kind), 32'(INST_JALR));
        check("jalr_fields", {out_rd, out_rs1, out_immediate[23:0]}, {4'd1, 4'd2, 24'd0});
        check("jalr_rf1", 32'(rf_read_loc_1), 32'd2);

        send(32'h00100813, 32'h108);
        @(negedge clock);
        check("range_err", {err_valid, in_ready, err_cause}, {1'b1, 1'b0, 2'd3});
        check("range_err_ins", err_instruction, 32'h00100813);
        check("range_err_pc", err_address, 32'h108);
        clear_err();
        @(negedge clock);
        check("range_clear", {err_valid, in_ready, err_cause}, {1'b0, 1'b1, 2'd0});

        send(32'h022081B3, 32'h10C);
        @(negedge clock);
`ifdef DECODE_MEXT_EN
        check("mul_kind", 32'(out_kind), 32'(INST_MUL));
        check("mul_regs", {out_rd, out_rs1, out_rs2}, {4'd3, 4'd1, 4'd2});
`else
        check("mul_err", {err_valid, err_cause}, {1'b1, 2'd2});
        clear_err();
`endif
        send(32'h00000000, 32'h110);
        @(negedge clock);
        check("zero_err", {err_valid, err_cause}, {1'b1, 2'd1});
        clear_err();

        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h00100093;
        for (int i = 0; i < 3; i++) begin
            in_address = 32'h200 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("full_ready", {in_ready, out_valid}, {1'b0, 1'b1});
        check("full_head", out_address, 32'h200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("flush", {out_valid, in_ready}, {1'b0, 1'b1});

        send(32'h00100093, 32'h300);
        in_valid = 1'b1; in_address = 32'h304; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        check("pushpop_1", {out_valid, out_address[30:0]}, {1'b1, 31'h304});
        in_valid = 1'b1; in_address = 32'h308; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        check("pushpop_wrap", {out_valid, out_address[30:0]}, {1'b1, 31'h308});
        tick();

        for (int c = 0; c < 3000; c++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_instruction = rand_instr();
            in_address     = $urandom() & 32'hFFFF_FFFC;
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 40) == 0);
            err_clear      = m_err_v ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 20) == 0);
            tick();
        end
        in_valid = 0; flush = 1; err_clear = 1;
        tick();
        flush = 0; err_clear = 0; out_ready = 0;

        send(32'h00500093, 32'h400);
        send(32'h00000000, 32'h404);
        @(posedge clock);
        #3 nreset = 1'b0;
        #1;
        check("midrst_out", {out_valid, in_ready, out_address[29:0]}, {1'b0, 1'b1, 30'd0});
        check("midrst_kind", 32'(out_kind), 32'(INST_NOP));
        check("midrst_err", {err_valid, err_cause, err_instruction[28:0]}, 32'd0);
        @(negedge clock);
        nreset = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
